// File: rtl/mu_proc_param_if.sv
// Request/acknowledge memory bus between mu_proc_param (master) and a shared
// single-port memory (slave).
interface mu_proc_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mu_proc_param.sv
// Parametrised accumulator processor with req/ack memory port, C/Z/N flags and
// start/halt control. Define MU_PROC_MUL_EN to make opcode F an unsigned MUL.
module mu_proc_param #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  mu_proc_param_if.master   bus,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        flags,
  output logic              halted,
  output logic              illegal
);

  generate
    if (DATA_W < ADDR_W + 4) begin : g_width_check
      $error("mu_proc_param: DATA_W must be >= ADDR_W+4");
    end
  endgenerate

  localparam logic [3:0] OP_LDA  = 4'h0, OP_STO = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4, OP_JGE = 4'h5, OP_JNE  = 4'h6, OP_STP  = 4'h7;
  localparam logic [3:0] OP_LDAI = 4'h8, OP_AND = 4'h9, OP_ADDI = 4'hA, OP_SUBI = 4'hB;
  localparam logic [3:0] OP_OR   = 4'hC, OP_XOR = 4'hD, OP_SHF  = 4'hE;
`ifdef MU_PROC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hF;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_WRITE, S_EXEC, S_HALT
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] mdata_reg;
  logic [3:0]        opcode_reg;
  logic [ADDR_W-1:0] operand_reg;
  logic              c_reg, z_reg, n_reg;
  logic              illegal_reg, halted_reg;
  logic              mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic [DATA_W-1:0]   imm, exec_acc;
  logic [DATA_W:0]     add_w, sub_w, addi_w, subi_w;
  logic [2*DATA_W-1:0] shl_w, shr_w;
`ifdef MU_PROC_MUL_EN
  logic [2*DATA_W-1:0] mul_w;
`endif
  logic exec_c, exec_wr, exec_jump, exec_halt, exec_illegal, needs_read;

  // Execute datapath; the widened shifters leave the last bit shifted out just
  // past the result, which is 0 for a zero shift amount.
  always_comb begin
    imm    = {{(DATA_W-ADDR_W){1'b0}}, operand_reg};
    add_w  = {1'b0, acc_reg} + {1'b0, mdata_reg};
    sub_w  = {1'b0, acc_reg} - {1'b0, mdata_reg};
    addi_w = {1'b0, acc_reg} + {1'b0, imm};
    subi_w = {1'b0, acc_reg} - {1'b0, imm};
    shl_w  = {{DATA_W{1'b0}}, acc_reg} << imm[4:0];
    shr_w  = {acc_reg, {DATA_W{1'b0}}} >> imm[4:0];
`ifdef MU_PROC_MUL_EN
    mul_w  = acc_reg * mdata_reg;
`endif
    exec_acc     = acc_reg;
    exec_c       = c_reg;
    exec_wr      = 1'b0;
    exec_jump    = 1'b0;
    exec_halt    = 1'b0;
    exec_illegal = 1'b0;
    needs_read   = 1'b0;
    case (opcode_reg)
      OP_LDA:  begin exec_acc = mdata_reg; exec_c = 1'b0; exec_wr = 1'b1; needs_read = 1'b1; end
      OP_STO:  ;
      OP_ADD:  begin {exec_c, exec_acc} = add_w; exec_wr = 1'b1; needs_read = 1'b1; end
      OP_SUB:  begin {exec_c, exec_acc} = sub_w; exec_wr = 1'b1; needs_read = 1'b1; end
      OP_JMP:  exec_jump = 1'b1;
      OP_JGE:  exec_jump = !n_reg;
      OP_JNE:  exec_jump = !z_reg;
      OP_STP:  exec_halt = 1'b1;
      OP_LDAI: begin exec_acc = imm; exec_c = 1'b0; exec_wr = 1'b1; end
      OP_AND:  begin exec_acc = acc_reg & mdata_reg; exec_c = 1'b0; exec_wr = 1'b1; needs_read = 1'b1; end
      OP_ADDI: begin {exec_c, exec_acc} = addi_w; exec_wr = 1'b1; end
      OP_SUBI: begin {exec_c, exec_acc} = subi_w; exec_wr = 1'b1; end
      OP_OR:   begin exec_acc = acc_reg | mdata_reg; exec_c = 1'b0; exec_wr = 1'b1; needs_read = 1'b1; end
      OP_XOR:  begin exec_acc = acc_reg ^ mdata_reg; exec_c = 1'b0; exec_wr = 1'b1; needs_read = 1'b1; end
      OP_SHF: begin
        exec_wr = 1'b1;
        if (operand_reg[ADDR_W-1]) begin
          exec_acc = shr_w[2*DATA_W-1:DATA_W];
          exec_c   = shr_w[DATA_W-1];
        end else begin
          exec_acc = shl_w[DATA_W-1:0];
          exec_c   = shl_w[DATA_W];
        end
      end
`ifdef MU_PROC_MUL_EN
      OP_MUL: begin
        exec_acc   = mul_w[DATA_W-1:0];
        exec_c     = |mul_w[2*DATA_W-1:DATA_W];
        exec_wr    = 1'b1;
        needs_read = 1'b1;
      end
`endif
      default: exec_illegal = 1'b1;
    endcase
  end

  // Each memory state spends its first cycle raising the request, so mem_req is
  // always low for at least one cycle after an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC;
      acc_reg       <= '0;
      mdata_reg     <= '0;
      opcode_reg    <= '0;
      operand_reg   <= '0;
      c_reg         <= 1'b0;
      z_reg         <= 1'b0;
      n_reg         <= 1'b0;
      illegal_reg   <= 1'b0;
      halted_reg    <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) state_reg <= S_FETCH;
        S_FETCH: begin
          if (!mem_req_reg) begin
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= pc_reg;
          end else if (bus.mem_ack) begin
            mem_req_reg <= 1'b0;
            opcode_reg  <= bus.mem_rdata[DATA_W-1 -: 4];
            operand_reg <= bus.mem_rdata[ADDR_W-1:0];
            pc_reg      <= pc_reg + ADDR_W'(1);
            state_reg   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode_reg == OP_STO) state_reg <= S_WRITE;
          else if (needs_read)      state_reg <= S_READ;
          else                      state_reg <= S_EXEC;
        end
        S_READ: begin
          if (!mem_req_reg) begin
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= operand_reg;
          end else if (bus.mem_ack) begin
            mem_req_reg <= 1'b0;
            mdata_reg   <= bus.mem_rdata;
            state_reg   <= S_EXEC;
          end
        end
        S_WRITE: begin
          if (!mem_req_reg) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= operand_reg;
            mem_wdata_reg <= acc_reg;
          end else if (bus.mem_ack) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            state_reg   <= S_FETCH;
          end
        end
        S_EXEC: begin
          if (exec_illegal) begin
            illegal_reg <= 1'b1;
            halted_reg  <= 1'b1;
            state_reg   <= S_HALT;
          end else if (exec_halt) begin
            halted_reg <= 1'b1;
            state_reg  <= S_HALT;
          end else begin
            if (exec_wr) begin
              acc_reg <= exec_acc;
              c_reg   <= exec_c;
              z_reg   <= (exec_acc == '0);
              n_reg   <= exec_acc[DATA_W-1];
            end
            if (exec_jump) pc_reg <= operand_reg;
            state_reg <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) begin
            halted_reg <= 1'b0;
            state_reg  <= S_FETCH;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign acc_out       = acc_reg;
  assign pc_out        = pc_reg;
  assign flags         = {c_reg, z_reg, n_reg};
  assign halted        = halted_reg;
  assign illegal       = illegal_reg;

endmodule

// File: doc/mu_proc_param.md
Name: mu_proc_param

Overview:
- Parametrised next-generation accumulator processor.
- Generalises data and address width, and moves program/data memory off-block behind a req/ack memory handshake.
- Adds carry/zero/negative flags, signed JGE, an illegal-opcode trap and a start/halt/resume control.
- Sits between the system controller and a shared single-port memory.

Parameters:
DATA_W, 16, accumulator/memory word width; must be >= ADDR_W+4, else elaboration error
ADDR_W, 12, address and operand width; instruction = {opcode[DATA_W-1:DATA_W-4], operand[ADDR_W-1:0]}, middle bits ignored
RESET_PC, 0, pc value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; leaves IDLE or HALT when sampled high
mem_req  out  1  memory request, held until acked
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  ADDR_W  request address; stable while mem_req
mem_wdata  out  DATA_W  write data (= acc); stable while mem_req
mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
mem_ack  in  1  completes the request in the cycle it is high with mem_req
acc_out  out  DATA_W  accumulator
pc_out  out  ADDR_W  program counter
flags  out  3  {C,Z,N}
halted  out  1  high in HALT
illegal  out  1  sticky; set by illegal opcode, cleared only by reset

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC; acc, ir, flags, illegal=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States:
  - IDLE -> FETCH on start.
  - FETCH: mem_req=1, we=0, addr=pc. On ack: ir<=rdata, pc<=pc+1 (wraps mod 2^ADDR_W), ->DECODE.
  - DECODE: memory-operand ops ->READ; STO ->WRITE; all others ->EXEC.
  - READ: req, addr=operand. On ack: latch operand data, ->EXEC.
  - WRITE: req, we=1, addr=operand, wdata=acc. On ack ->FETCH.
  - EXEC: one cycle, update acc/flags/pc, ->FETCH. STP or illegal ->HALT.
  - HALT: halted=1. On start ->FETCH at current pc (resume after STP).
- mem_req drops the cycle after ack. At most one request outstanding. ack without req is ignored.
- Opcodes (M = mem[operand], I = zero-extended operand):
  - 0 LDA acc=M
  - 1 STO M=acc
  - 2 ADD acc+=M
  - 3 SUB acc-=M
  - 4 JMP pc=operand
  - 5 JGE pc=operand if N==0
  - 6 JNE pc=operand if Z==0
  - 7 STP
  - 8 LDAI acc=I
  - 9 AND acc&=M
  - A ADDI acc+=I
  - B SUBI acc-=I
  - C OR acc|=M
  - D XOR acc^=M
  - E SHF: operand[ADDR_W-1]=0 shifts left, 1 shifts logical right, by operand[4:0] (amount >= DATA_W gives 0)
  - F MUL (optional)
- Flags:
  - Z = (acc==0) and N = acc[DATA_W-1], both updated by every acc-writing op.
  - C: ADD/ADDI carry out. SUB/SUBI borrow (1 when acc < subtrahend unsigned). SHF last bit shifted out, 0 if amount 0.
  - Logic ops and loads clear C.
  - Jumps, STO and STP leave flags unchanged.
- Arithmetic is modulo 2^DATA_W.
- Jumps use flags as set by the previous instruction.

Optional Feature:
- Macro MU_PROC_MUL_EN.
- Defined: opcode F is MUL. acc = low DATA_W bits of acc*M (unsigned). C=1 if the upper DATA_W bits are nonzero. Z/N updated. Execute is one cycle.
- Undefined: opcode F is illegal. No memory read is issued; DECODE goes straight to EXEC, which sets illegal=1 and enters HALT. acc, flags and pc remain unchanged apart from the fetch increment.

Test Plan:
- Program: LDAI 5; SUBI 3; STO FFF; STP. Memory model acks reads after 1 cycle and writes after 0 cycles -> write of 0x0002 to 0xFFF; flags C=0 Z=0 N=0; halted=1; pc_out=4.
- LDAI 3; SUBI 5 -> acc=0xFFFE, C=1, N=1, Z=0. A following JGE 0x010 is not taken; pc continues sequentially.
- mem[0x100]=0x0007. LDA 100; XOR 100 -> acc=0, Z=1. A following JNE 0x020 is not taken.
- mem_ack held low for 10 cycles during FETCH -> mem_req, mem_addr and mem_we stay stable throughout. No state advance until ack.
- Opcode F with MU_PROC_MUL_EN: acc=0x0300, M=0x0100 -> acc=0x0000, C=1, Z=1. Without the macro: illegal=1, halted=1, mem_req not raised for the operand.
- reset asserted in a WRITE wait cycle -> mem_req=0 immediately (async). After release: IDLE, pc=RESET_PC. start high -> fetch from RESET_PC.
